// File: rtl/step_motor_controller.sv
// Full-step stepper controller: debounced-free speed buttons, per-speed step timer,
// four-phase coil sequencer and a free-running one-hot digit scanner.
module step_motor_controller #(
  parameter int unsigned PERIOD_1    = 4000000,
  parameter int unsigned PERIOD_2    = 2000000,
  parameter int unsigned PERIOD_3    = 1000000,
  parameter int unsigned SCAN_PERIOD = 100000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       speedUp,
  input  logic       speedDown,
  input  logic       direction,
  input  logic       motorEnable,
  output logic [1:0] motorSpeed,
  output logic [3:0] switchEnabler,
  output logic [3:0] coils,
  output logic       stepPulse
);

  localparam int unsigned PMAX = (PERIOD_1 >= PERIOD_2) ?
                                 ((PERIOD_1 >= PERIOD_3) ? PERIOD_1 : PERIOD_3) :
                                 ((PERIOD_2 >= PERIOD_3) ? PERIOD_2 : PERIOD_3);
  localparam int unsigned TW = $clog2(PMAX + 1);
  localparam int unsigned SW = $clog2(SCAN_PERIOD + 1);
  localparam logic [TW-1:0] P1_LAST   = TW'(PERIOD_1 - 1);
  localparam logic [TW-1:0] P2_LAST   = TW'(PERIOD_2 - 1);
  localparam logic [TW-1:0] P3_LAST   = TW'(PERIOD_3 - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  logic          up_meta_q, up_sync_q, up_prev_q, up_arm_q, up_arm_d;
  logic          dn_meta_q, dn_sync_q, dn_prev_q, dn_arm_q, dn_arm_d;
  logic          settled_q;
  logic          up_pulse, dn_pulse;
  logic [1:0]    speed_q, speed_d;
  logic          speed_chg, running, tick;
  logic [TW-1:0] period_last, timer_q, timer_d;
  logic          step_q, step_d;
  phase_e        phase_q, phase_d;
  logic [3:0]    coils_q, coils_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [3:0]    sel_q, sel_d;

  always_comb begin
    // A button is armed only once it has been seen low after reset, so a press
    // held through reset release cannot fire until released and pressed again.
    up_arm_d = up_arm_q | (settled_q & ~up_meta_q);
    dn_arm_d = dn_arm_q | (settled_q & ~dn_meta_q);
    up_pulse = up_sync_q & ~up_prev_q & up_arm_q;
    dn_pulse = dn_sync_q & ~dn_prev_q & dn_arm_q;

    speed_d = speed_q;
    if (up_pulse && !dn_pulse && speed_q != 2'd3)      speed_d = speed_q + 2'd1;
    else if (dn_pulse && !up_pulse && speed_q != 2'd0) speed_d = speed_q - 2'd1;
    speed_chg = (speed_d != speed_q);

    case (speed_q)
      2'd1:    period_last = P1_LAST;
      2'd2:    period_last = P2_LAST;
      default: period_last = P3_LAST;
    endcase

    running = motorEnable && (speed_q != 2'd0);
    tick    = running && !speed_chg && (timer_q == period_last);
    timer_d = (!running || speed_chg || tick) ? '0 : timer_q + 1'b1;
    step_d  = tick;

    phase_d = phase_q;
    if (tick) begin
      case (phase_q)
        PH0:     phase_d = direction ? PH1 : PH3;
        PH1:     phase_d = direction ? PH2 : PH0;
        PH2:     phase_d = direction ? PH3 : PH1;
        default: phase_d = direction ? PH0 : PH2;
      endcase
    end

    coils_d = '0;
    if (speed_d != 2'd0 && motorEnable) begin
      case (phase_d)
        PH0:     coils_d = 4'b1100;
        PH1:     coils_d = 4'b0110;
        PH2:     coils_d = 4'b0011;
        default: coils_d = 4'b1001;
      endcase
    end

    scan_d = scan_q + 1'b1;
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = {sel_q[2:0], sel_q[3]};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      up_prev_q <= 1'b0;
      up_arm_q  <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
      dn_prev_q <= 1'b0;
      dn_arm_q  <= 1'b0;
      settled_q <= 1'b0;
      speed_q   <= '0;
      timer_q   <= '0;
      step_q    <= 1'b0;
      phase_q   <= PH0;
      coils_q   <= '0;
      scan_q    <= '0;
      sel_q     <= 4'b0001;
    end else begin
      up_meta_q <= speedUp;
      up_sync_q <= up_meta_q;
      up_prev_q <= up_sync_q;
      up_arm_q  <= up_arm_d;
      dn_meta_q <= speedDown;
      dn_sync_q <= dn_meta_q;
      dn_prev_q <= dn_sync_q;
      dn_arm_q  <= dn_arm_d;
      settled_q <= 1'b1;
      speed_q   <= speed_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      phase_q   <= phase_d;
      coils_q   <= coils_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
    end
  end

  assign motorSpeed    = speed_q;
  assign switchEnabler = sel_q;
  assign coils         = coils_q;
  assign stepPulse     = step_q;

endmodule

// File: tb/tb_step_motor_controller.sv
// Directed bench for step_motor_controller with short periods (8/4/2, scan 3).
module tb_step_motor_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       speedUp, speedDown, direction, motorEnable;
  logic [1:0] motorSpeed;
  logic [3:0] switchEnabler, coils;
  logic       stepPulse;

  int unsigned checks = 0;
  int unsigned errors = 0;

  step_motor_controller #(
    .PERIOD_1(8), .PERIOD_2(4), .PERIOD_3(2), .SCAN_PERIOD(3)
  ) dut (
    .clk(clk), .resetN(resetN), .speedUp(speedUp), .speedDown(speedDown),
    .direction(direction), .motorEnable(motorEnable), .motorSpeed(motorSpeed),
    .switchEnabler(switchEnabler), .coils(coils), .stepPulse(stepPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic press(input logic up, input logic dn);
    speedUp = up; speedDown = dn;
    @(negedge clk);
    speedUp = 1'b0; speedDown = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [3:0] fwd [4];
  logic [1:0] up_exp [4];
  logic [1:0] dn_exp [5];
  logic       found;

  initial begin
    fwd    = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
    up_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
    dn_exp = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    resetN = 1'b0; speedUp = 1'b0; speedDown = 1'b0;
    direction = 1'b1; motorEnable = 1'b0;

    @(negedge clk);
    check("rst_speed", {2'b00, motorSpeed}, 4'd0);
    check("rst_coils", coils, 4'b0000);
    check("rst_step", {3'b000, stepPulse}, 4'd0);
    check("rst_sel", switchEnabler, 4'b0001);

    // Free-running scan: rotates after every third rising edge
    resetN = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("scan_%0d", i), switchEnabler, 4'b0001 << ((i / 3) % 4));
    end

    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0);
      check($sformatf("up_%0d", i), {2'b00, motorSpeed}, {2'b00, up_exp[i]});
    end
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1);
      check($sformatf("dn_%0d", i), {2'b00, motorSpeed}, {2'b00, dn_exp[i]});
    end
    check("dis_coils", coils, 4'b0000);

    // Speed 1 forward stepping
    motorEnable = 1'b1; direction = 1'b1;
    press(1'b1, 1'b0);
    check("s1_speed", {2'b00, motorSpeed}, 4'd1);
    check("s1_coils0", coils, 4'b1100);
    for (int s = 0; s < 4; s++) begin
      repeat (7) @(negedge clk);
      check($sformatf("s1_gap_%0d", s), {3'b000, stepPulse}, 4'd0);
      @(negedge clk);
      check($sformatf("s1_pulse_%0d", s), {3'b000, stepPulse}, 4'd1);
      check($sformatf("s1_coils_%0d", s), coils, fwd[s]);
    end
    direction = 1'b0;
    repeat (7) @(negedge clk);
    check("rev_gap", {3'b000, stepPulse}, 4'd0);
    @(negedge clk);
    check("rev_pulse", {3'b000, stepPulse}, 4'd1);
    check("rev_coils", coils, 4'b1001);

    // Speed 3, then drop to 2 and confirm timer restart
    press(1'b1, 1'b0);
    check("s2_speed", {2'b00, motorSpeed}, 4'd2);
    press(1'b1, 1'b0);
    check("s3_speed", {2'b00, motorSpeed}, 4'd3);
    check("s3_nopulse", {3'b000, stepPulse}, 4'd0);
    @(negedge clk); check("s3_gap0", {3'b000, stepPulse}, 4'd0);
    @(negedge clk); check("s3_pulse0", {3'b000, stepPulse}, 4'd1);
    check("s3_coils0", coils, 4'b0011);
    @(negedge clk); check("s3_gap1", {3'b000, stepPulse}, 4'd0);
    @(negedge clk); check("s3_pulse1", {3'b000, stepPulse}, 4'd1);
    check("s3_coils1", coils, 4'b0110);
    press(1'b0, 1'b1);
    check("drop_speed", {2'b00, motorSpeed}, 4'd2);
    check("drop_nopulse", {3'b000, stepPulse}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("drop_gap_%0d", i), {3'b000, stepPulse}, 4'd0);
    end
    @(negedge clk);
    check("drop_pulse", {3'b000, stepPulse}, 4'd1);
    check("drop_coils", coils, 4'b1001);

    // Simultaneous press, then enable gating
    press(1'b1, 1'b1);
    check("both_speed", {2'b00, motorSpeed}, 4'd2);
    @(negedge clk);
    check("both_pulse", {3'b000, stepPulse}, 4'd1);
    check("both_coils", coils, 4'b0011);
    motorEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("off_step_%0d", i), {3'b000, stepPulse}, 4'd0);
      check($sformatf("off_coils_%0d", i), coils, 4'b0000);
    end
    motorEnable = 1'b1;
    @(negedge clk);
    check("on_coils", coils, 4'b0011);
    check("on_step", {3'b000, stepPulse}, 4'd0);

    // Asynchronous reset in the middle of a scan slot
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (switchEnabler == 4'b0100) found = 1'b1;
    end
    check("scan_wait", {3'b000, found}, 4'd1);
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    check("arst_sel", switchEnabler, 4'b0001);
    check("arst_speed", {2'b00, motorSpeed}, 4'd0);
    check("arst_coils", coils, 4'b0000);
    check("arst_step", {3'b000, stepPulse}, 4'd0);

    // Button held through reset release must not count
    speedUp = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    repeat (6) @(negedge clk);
    check("held_speed", {2'b00, motorSpeed}, 4'd0);
    speedUp = 1'b0;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0);
    check("repress_speed", {2'b00, motorSpeed}, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_motor_controller.md
STEP_MOTOR_CONTROLLER -- requirements
Module: step_motor_controller

Interface
REQ-001 SHALL have parameter PERIOD_1, default 4000000: clock cycles per step at speed 1.
REQ-002 SHALL have parameter PERIOD_2, default 2000000: clock cycles per step at speed 2.
REQ-003 SHALL have parameter PERIOD_3, default 1000000: clock cycles per step at speed 3.
REQ-004 SHALL have parameter SCAN_PERIOD, default 100000: clock cycles per display digit slot.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, all state on its rising edge.
REQ-006 SHALL have port resetN, input, 1 bit: reset is asynchronous and active-low.
REQ-007 SHALL have port speedUp, input, 1 bit: raw asynchronous button, increments speed.
REQ-008 SHALL have port speedDown, input, 1 bit: raw asynchronous button, decrements speed.
REQ-009 SHALL have port direction, input, 1 bit: 1 forward, 0 reverse; quasi-static switch.
REQ-010 SHALL have port motorEnable, input, 1 bit: 0 de-energizes coils and freezes stepping.
REQ-011 SHALL have port motorSpeed, output, 2 bits: current speed 0..3; feeds the segment decoder.
REQ-012 SHALL have port switchEnabler, output, 4 bits: one-hot digit-scan select; feeds the digit selector.
REQ-013 SHALL have port coils, output, 4 bits: motor coil drive pattern.
REQ-014 SHALL have port stepPulse, output, 1 bit: one-cycle strobe on every phase advance.

Function
REQ-015 speedUp and speedDown SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse.
REQ-016 Speed update latency SHALL be 3 clocks: a button high before edge N shows on motorSpeed after edge N+2.
REQ-017 Up pulse SHALL increment motorSpeed, saturating at 3; down pulse SHALL decrement, saturating at 0; no wrap-around.
REQ-018 Up and down pulses in the same cycle SHALL leave motorSpeed unchanged.
REQ-019 Step timer SHALL count 0..PERIOD_s-1 for current speed s, asserting stepPulse for the one cycle where count equals PERIOD_s-1, then returning to 0.
REQ-020 Any motorSpeed change SHALL clear the step timer to 0 in the same edge as the speed update; no stepPulse in that cycle.
REQ-021 When motorSpeed=0 or motorEnable=0, step timer SHALL hold at 0 and stepPulse SHALL stay 0.
REQ-022 Phase FSM SHALL have four states PH0..PH3 driving coils 1100, 0110, 0011, 1001 respectively (full-step, two coils on).
REQ-023 On stepPulse, phase SHALL advance PH0->PH1->PH2->PH3->PH0 when direction=1, and reverse order when direction=0, wrapping at both ends.
REQ-024 direction SHALL be sampled only on the stepPulse cycle; changes between steps take effect on the next step.
REQ-025 coils SHALL be 0000 whenever motorSpeed=0 or motorEnable=0; phase state SHALL be retained and resume from the same pattern.
REQ-026 Scan counter SHALL count 0..SCAN_PERIOD-1 continuously, independent of speed and enable; at terminal count switchEnabler SHALL rotate 0001->0010->0100->1000->0001.
REQ-027 switchEnabler SHALL always be exactly one-hot.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 While resetN=0: motorSpeed=0, coils=0000, stepPulse=0, switchEnabler=0001, phase=PH0, all counters and synchronizer flops 0.
REQ-030 Reset assertion mid-step or mid-scan SHALL take effect immediately, without waiting for a clock edge; on release, operation restarts from the reset state on the first rising clk edge.
REQ-031 A button held high across reset release SHALL NOT produce a speed pulse until it is released and pressed again.

Verification (PERIOD_1=8, PERIOD_2=4, PERIOD_3=2, SCAN_PERIOD=3)
REQ-032 Reset, then four speedUp presses -> motorSpeed 1,2,3,3; then five speedDown presses -> 2,1,0,0,0.
REQ-033 Speed 1, direction=1, enable=1 -> stepPulse every 8 clocks; coils 0110,0011,1001,1100 in order; flip direction -> next step returns to the previous pattern.
REQ-034 Speed 3 -> stepPulse every 2 clocks; press speedDown mid-period -> timer restarts and next step arrives 4 clocks after the speed update.
REQ-035 speedUp and speedDown pressed together -> motorSpeed unchanged; motorEnable=0 at speed 2 -> coils 0000 and no stepPulse; re-enable -> coils resume the retained phase pattern.
REQ-036 Free run after reset -> switchEnabler changes every 3 clocks through 0001,0010,0100,1000,0001; assert resetN=0 mid-slot -> immediately 0001, with motorSpeed=0 and coils=0000.
